// File: rtl/core_array_gbus_sched_pkg.sv
// Shared types for the per-head GBUS scheduler.
//   state_e : scheduler FSM states
//   cmd_t   : latched burst command {rd, core_mask, base_addr, len}
//   DEF_*   : default geometry used by the interface and the top level
package gbus_sched_pkg;

  localparam int unsigned DEF_VNUM      = 8;
  localparam int unsigned DEF_GBUS_DATA = 64;
  localparam int unsigned DEF_GBUS_ADDR = 12;
  localparam int unsigned DEF_LEN_W     = 12;
  localparam int unsigned DEF_MAX_OUTST = 4;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    WR,
    RD,
    DRAIN,
    DONE
  } state_e;

  typedef struct packed {
    logic                     rd;
    logic [DEF_VNUM-1:0]      core_mask;
    logic [DEF_GBUS_ADDR-1:0] base_addr;
    logic [DEF_LEN_W-1:0]     len;
  } cmd_t;

endpackage

// File: rtl/core_array_gbus_sched_if.sv
// Bundle of all handshake/bus signals of one GBUS scheduler instance.
//   cmd_*        : burst command handshake (controller -> scheduler)
//   s_*          : write-data stream (controller -> scheduler)
//   gbus_*       : core_array GBUS side (addr/wen/wdata/ren out, rvalid/rdata in)
//   m_*          : read-return stream, no backpressure
//   busy, done   : status
// Modports: master = controller/core_array side, slave = scheduler.
interface core_array_gbus_sched_if
  import gbus_sched_pkg::*;
#(
  parameter int unsigned VNUM      = DEF_VNUM,
  parameter int unsigned GBUS_DATA = DEF_GBUS_DATA,
  parameter int unsigned GBUS_ADDR = DEF_GBUS_ADDR,
  parameter int unsigned LEN_W     = DEF_LEN_W
) ();

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_rd;
  logic [VNUM-1:0]      cmd_core_mask;
  logic [GBUS_ADDR-1:0] cmd_base_addr;
  logic [LEN_W-1:0]     cmd_len;
  logic                 s_valid;
  logic                 s_ready;
  logic [GBUS_DATA-1:0] s_data;
  logic [GBUS_ADDR-1:0] gbus_addr;
  logic [VNUM-1:0]      gbus_wen;
  logic [GBUS_DATA-1:0] gbus_wdata;
  logic [VNUM-1:0]      gbus_ren;
  logic [VNUM-1:0]      gbus_rvalid;
  logic [GBUS_DATA-1:0] gbus_rdata;
  logic                 m_valid;
  logic [GBUS_DATA-1:0] m_data;
  logic                 busy;
  logic                 done;

  modport master (
    output cmd_valid, cmd_rd, cmd_core_mask, cmd_base_addr, cmd_len,
    output s_valid, s_data, gbus_rvalid, gbus_rdata,
    input  cmd_ready, s_ready, gbus_addr, gbus_wen, gbus_wdata, gbus_ren,
    input  m_valid, m_data, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_rd, cmd_core_mask, cmd_base_addr, cmd_len,
    input  s_valid, s_data, gbus_rvalid, gbus_rdata,
    output cmd_ready, s_ready, gbus_addr, gbus_wen, gbus_wdata, gbus_ren,
    output m_valid, m_data, busy, done
  );

endinterface

// File: rtl/core_array_gbus_sched_prienc.sv
// Lowest-set-bit priority encoder.
//   req    : request vector
//   onehot : lowest set bit of req (all zero when req is zero)
//   idx    : index of that bit (zero when req is zero)
module gbus_sched_prienc #(
  parameter  int unsigned N  = 8,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  always_comb begin
    // two's-complement trick isolates the lowest set bit
    onehot = req & (~req + N'(1));
    idx    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (onehot[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/core_array_gbus_sched.sv
// Per-head GBUS scheduler: accepts one write or read burst, visits the
// selected cores in ascending order and issues len words per core starting at
// base_addr (wrapping modulo 2**GBUS_ADDR).
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of core_array_gbus_sched_if (command, write stream,
//              GBUS strobes, read-return stream, busy/done)
// All bus outputs except cmd_ready/s_ready are registered.
module core_array_gbus_sched
  import gbus_sched_pkg::*;
#(
  parameter int unsigned VNUM      = DEF_VNUM,
  parameter int unsigned GBUS_DATA = DEF_GBUS_DATA,
  parameter int unsigned GBUS_ADDR = DEF_GBUS_ADDR,
  parameter int unsigned LEN_W     = DEF_LEN_W,
  parameter int unsigned MAX_OUTST = DEF_MAX_OUTST
) (
  input logic                    clk,
  input logic                    rst,
  core_array_gbus_sched_if.slave bus
);

  localparam int unsigned IW = (VNUM > 1) ? $clog2(VNUM) : 1;
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);

  state_e               state, state_nx;
  cmd_t                 cmd_q;         // core_mask doubles as the remaining-core mask
  logic [IW-1:0]        core_idx;
  logic [VNUM-1:0]      core_oh;
  logic [GBUS_ADDR-1:0] cur_addr;
  logic [LEN_W-1:0]     word_cnt;
  logic [OW-1:0]        outst;
  logic [VNUM-1:0]      pick_oh;
  logic [IW-1:0]        pick_idx;
  logic                 accept, wr_fire, rd_fire, last_word, rvalid_any;

  logic [GBUS_ADDR-1:0] addr_q;
  logic [VNUM-1:0]      wen_q, ren_q;
  logic [GBUS_DATA-1:0] wdata_q, mdata_q;
  logic                 mvalid_q, busy_q, done_q;

  gbus_sched_prienc #(.N(VNUM)) u_prienc (
    .req    (cmd_q.core_mask),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  assign core_oh    = VNUM'(1) << core_idx;
  assign rvalid_any = |bus.gbus_rvalid;
  assign last_word  = (word_cnt == cmd_q.len - LEN_W'(1));

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    wr_fire  = 1'b0;
    rd_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          accept   = 1'b1;
          state_nx = (bus.cmd_core_mask == '0 || bus.cmd_len == '0) ? DONE : SEL;
        end
      end
      SEL: state_nx = cmd_q.rd ? RD : WR;
      WR: begin
        if (bus.s_valid) begin
          wr_fire = 1'b1;
          if (last_word) state_nx = (cmd_q.core_mask != '0) ? SEL : DONE;
        end
      end
      RD: begin
        if (outst < OW'(MAX_OUTST)) begin
          rd_fire = 1'b1;
          if (last_word) state_nx = (cmd_q.core_mask != '0) ? SEL : DRAIN;
        end
      end
      DRAIN: if (outst == '0) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cmd_q    <= '0;
      core_idx <= '0;
      cur_addr <= '0;
      word_cnt <= '0;
      outst    <= '0;
      addr_q   <= '0;
      wen_q    <= '0;
      ren_q    <= '0;
      wdata_q  <= '0;
      mvalid_q <= 1'b0;
      mdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cmd_q <= '{rd: bus.cmd_rd, core_mask: bus.cmd_core_mask,
                   base_addr: bus.cmd_base_addr, len: bus.cmd_len};
      end
      if (state == SEL) begin
        cmd_q.core_mask <= cmd_q.core_mask & ~pick_oh;
        core_idx        <= pick_idx;
        cur_addr        <= cmd_q.base_addr;
        word_cnt        <= '0;
      end
      wen_q <= wr_fire ? core_oh : '0;
      ren_q <= rd_fire ? core_oh : '0;
      if (wr_fire || rd_fire) begin
        addr_q   <= cur_addr;
        cur_addr <= cur_addr + GBUS_ADDR'(1);
        word_cnt <= word_cnt + LEN_W'(1);
      end
      if (wr_fire) wdata_q <= bus.s_data;
      outst    <= outst + OW'(rd_fire) - OW'(rvalid_any);
      mvalid_q <= rvalid_any;
      mdata_q  <= bus.gbus_rdata;
      // done is registered from DONE, so busy is stretched to cover the done cycle
      busy_q   <= (state_nx != IDLE) || (state == DONE);
      done_q   <= (state == DONE);
    end
  end

  assign bus.cmd_ready  = (state == IDLE);
  assign bus.s_ready    = (state == WR);
  assign bus.gbus_addr  = addr_q;
  assign bus.gbus_wen   = wen_q;
  assign bus.gbus_ren   = ren_q;
  assign bus.gbus_wdata = wdata_q;
  assign bus.m_valid    = mvalid_q;
  assign bus.m_data     = mdata_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_core_array_gbus_sched.sv
// Self-checking bench for core_array_gbus_sched: directed and randomized
// bursts compared against an address/data list built from the burst rules.
module tb_core_array_gbus_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  core_array_gbus_sched_if bus ();

  core_array_gbus_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int unsigned core;
    logic [11:0] addr;
    logic [63:0] data;
  } ev_t;

  int unsigned checks = 0;
  int unsigned fails  = 0;
  int unsigned cyc    = 0;

  ev_t         wr_obs[$];
  ev_t         rd_obs[$];
  logic [63:0] wsent[$];
  logic [63:0] m_exp[$];
  logic [63:0] m_obs[$];
  int unsigned due_t[$];
  logic [7:0]  due_bit[$];
  int unsigned done_cnt, done_t, last_act_t, acc_t, issued, returned, max_infl, rd_lat;
  int          smode;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned oh_idx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 99;
  endfunction

  // One clock: sample outputs #1 after the edge, then drive the next inputs.
  task automatic step();
    logic s_fire;
    logic excl;
    s_fire = bus.s_valid && bus.s_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (s_fire) begin
      wsent.push_back(bus.s_data);
      bus.s_data = {$urandom, $urandom};
    end
    excl = ($countones(bus.gbus_wen) <= 1) && ($countones(bus.gbus_ren) <= 1) &&
           !((|bus.gbus_wen) && (|bus.gbus_ren));
    chk("strobe_onehot_excl", 64'(excl), 64'd1);
    if (|bus.gbus_wen) begin
      wr_obs.push_back('{oh_idx(bus.gbus_wen), bus.gbus_addr, bus.gbus_wdata});
      last_act_t = cyc;
    end
    if (|bus.gbus_ren) begin
      rd_obs.push_back('{oh_idx(bus.gbus_ren), bus.gbus_addr, 64'd0});
      issued++;
      if (issued - returned > max_infl) max_infl = issued - returned;
      due_t.push_back(cyc + rd_lat);
      due_bit.push_back(bus.gbus_ren);
      last_act_t = cyc;
    end
    if (bus.m_valid) begin
      m_obs.push_back(bus.m_data);
      last_act_t = cyc;
    end
    if (bus.done) begin
      done_cnt++;
      done_t = cyc;
    end
    if (due_t.size() != 0 && due_t[0] == cyc) begin
      void'(due_t.pop_front());
      bus.gbus_rvalid = due_bit.pop_front();
      bus.gbus_rdata  = {$urandom, $urandom};
      m_exp.push_back(bus.gbus_rdata);
      returned++;
    end else begin
      bus.gbus_rvalid = '0;
      bus.gbus_rdata  = '0;
    end
    case (smode)
      1:       bus.s_valid = 1'b1;
      2:       bus.s_valid = ~bus.s_valid;
      3:       bus.s_valid = 1'($urandom_range(0, 1));
      default: bus.s_valid = 1'b0;
    endcase
  endtask

  task automatic clear_track();
    wr_obs.delete(); rd_obs.delete(); wsent.delete();
    m_exp.delete();  m_obs.delete();  due_t.delete(); due_bit.delete();
    done_cnt = 0; done_t = 0; last_act_t = 0;
    issued = 0; returned = 0; max_infl = 0;
  endtask

  task automatic issue_cmd(input logic rd, input logic [7:0] mask, input logic [11:0] base,
                           input logic [11:0] len, input string tag);
    logic acc;
    int   n;
    bus.cmd_valid     = 1'b1;
    bus.cmd_rd        = rd;
    bus.cmd_core_mask = mask;
    bus.cmd_base_addr = base;
    bus.cmd_len       = len;
    n = 0;
    do begin
      acc   = bus.cmd_ready;
      acc_t = cyc;
      step();
      n++;
    end while (!acc && n < 20);
    bus.cmd_valid = 1'b0;
    chk({tag, "_cmd_accepted"}, 64'(acc), 64'd1);
  endtask

  task automatic run_burst(input logic rd, input logic [7:0] mask, input logic [11:0] base,
                           input logic [11:0] len, input int sm, input int unsigned lat,
                           input string tag);
    ev_t         exp_ev[$];
    logic [11:0] a;
    int unsigned nexp;
    clear_track();
    rd_lat = lat;
    smode  = sm;
    issue_cmd(rd, mask, base, len, tag);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) step();
    smode = 0;
    repeat (8) step();
    for (int c = 0; c < 8; c++) begin
      if (mask[c]) begin
        for (int k = 0; k < int'(len); k++) begin
          a = base + 12'(k);
          exp_ev.push_back('{c, a, 64'd0});
        end
      end
    end
    nexp = exp_ev.size();
    if (!rd) begin
      chk({tag, "_wr_count"}, 64'(wr_obs.size()), 64'(nexp));
      chk({tag, "_rd_count"}, 64'(rd_obs.size()), 64'd0);
      chk({tag, "_words_taken"}, 64'(wsent.size()), 64'(nexp));
      for (int j = 0; j < int'(nexp) && j < wr_obs.size() && j < wsent.size(); j++) begin
        chk($sformatf("%s_wr%0d_core", tag, j), 64'(wr_obs[j].core), 64'(exp_ev[j].core));
        chk($sformatf("%s_wr%0d_addr", tag, j), 64'(wr_obs[j].addr), 64'(exp_ev[j].addr));
        chk($sformatf("%s_wr%0d_data", tag, j), wr_obs[j].data, wsent[j]);
      end
    end else begin
      chk({tag, "_rd_count"}, 64'(rd_obs.size()), 64'(nexp));
      chk({tag, "_wr_count"}, 64'(wr_obs.size()), 64'd0);
      chk({tag, "_beats"}, 64'(m_obs.size()), 64'(nexp));
      chk({tag, "_max_outst_le4"}, 64'(max_infl <= 4), 64'd1);
      for (int j = 0; j < int'(nexp) && j < rd_obs.size(); j++) begin
        chk($sformatf("%s_rd%0d_core", tag, j), 64'(rd_obs[j].core), 64'(exp_ev[j].core));
        chk($sformatf("%s_rd%0d_addr", tag, j), 64'(rd_obs[j].addr), 64'(exp_ev[j].addr));
      end
      for (int j = 0; j < m_obs.size() && j < m_exp.size(); j++)
        chk($sformatf("%s_beat%0d_data", tag, j), m_obs[j], m_exp[j]);
    end
    chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    chk({tag, "_done_after_last"}, 64'(done_t > last_act_t), 64'd1);
    chk({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
    chk({tag, "_ready_end"}, 64'(bus.cmd_ready), 64'd1);
  endtask

  initial begin
    bus.cmd_valid     = 1'b0;
    bus.cmd_rd        = 1'b0;
    bus.cmd_core_mask = '0;
    bus.cmd_base_addr = '0;
    bus.cmd_len       = '0;
    bus.s_valid       = 1'b0;
    bus.s_data        = {$urandom, $urandom};
    bus.gbus_rvalid   = '0;
    bus.gbus_rdata    = '0;
    smode  = 0;
    rd_lat = 3;
    clear_track();

    repeat (3) step();
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
    chk("rst_wen", 64'(bus.gbus_wen), 64'd0);
    chk("rst_ren", 64'(bus.gbus_ren), 64'd0);
    chk("rst_addr", 64'(bus.gbus_addr), 64'd0);
    chk("rst_wdata", bus.gbus_wdata, 64'd0);
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    rst = 1'b0;
    repeat (2) step();

    run_burst(1'b0, 8'b0000_0101, 12'h010, 12'd3, 1, 3, "wr_const");
    run_burst(1'b0, 8'b0000_0101, 12'h010, 12'd3, 2, 3, "wr_toggle");
    run_burst(1'b1, 8'h80, 12'h020, 12'd8, 0, 3, "rd_throttle");
    chk("rd_throttle_reaches4", 64'(max_infl), 64'd4);

    run_burst(1'b0, 8'h00, 12'h100, 12'd5, 1, 3, "mask0");
    chk("mask0_done_latency", 64'(done_t - acc_t), 64'd2);
    run_burst(1'b1, 8'h0F, 12'h100, 12'd0, 0, 3, "len0");
    chk("len0_done_latency", 64'(done_t - acc_t), 64'd2);

    run_burst(1'b0, 8'h02, 12'hFFE, 12'd4, 1, 3, "wrap");
    if (wr_obs.size() == 4) begin
      chk("wrap_addr2", 64'(wr_obs[2].addr), 64'h000);
      chk("wrap_addr3", 64'(wr_obs[3].addr), 64'h001);
    end else begin
      chk("wrap_count", 64'(wr_obs.size()), 64'd4);
    end

    // reset in the middle of a long write burst
    clear_track();
    smode = 1;
    issue_cmd(1'b0, 8'hFF, 12'h100, 12'd10, "rstmid");
    repeat (6) step();
    chk("rstmid_writes_started", 64'(wr_obs.size() > 0), 64'd1);
    rst = 1'b1;
    step();
    chk("rstmid_wen", 64'(bus.gbus_wen), 64'd0);
    chk("rstmid_ren", 64'(bus.gbus_ren), 64'd0);
    chk("rstmid_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rstmid_s_ready", 64'(bus.s_ready), 64'd0);
    chk("rstmid_busy", 64'(bus.busy), 64'd0);
    chk("rstmid_done", 64'(bus.done), 64'd0);
    rst   = 1'b0;
    smode = 0;
    repeat (10) step();
    chk("rstmid_no_done", 64'(done_cnt), 64'd0);
    chk("rstmid_idle_busy", 64'(bus.busy), 64'd0);

    for (int r = 0; r < 8; r++) begin
      run_burst(1'($urandom_range(0, 1)), 8'($urandom), 12'($urandom),
                12'($urandom_range(1, 6)), 3, $urandom_range(1, 6),
                $sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
